axis_pid_scheduler: RTL

Shares one PID compute engine between the X and Y galvo axes. Captures ADC samples per axis as they arrive and arbitrates them round-robin into the PID engine with a start/done handshake. Routes each result to that axis's DAC data register with a one-cycle load strobe. Sits between the two ADC interfaces, one pos_pid-style engine and the two DAC interfaces; counts overruns and engine timeouts for SPI readback.

---
 rtl/galvano_pkg.sv | 8 +
 rtl/rr_arb2.sv | 11 +
 rtl/axis_pid_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/galvano_pkg.sv
// galvano_pkg: shared widths, axis encoding, FSM states and DAC reset code for the galvo blocks
package galvano_pkg;
  localparam int DATA_W = 16;
  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;
  localparam logic [15:0] DAC_RST_CODE = 16'h8000;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_LOAD} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant, favouring the side that was not granted last
module rr_arb2 (
  input  logic req_x_i,
  input  logic req_y_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_axis_o
);
  assign gnt_valid_o = req_x_i | req_y_i;
  assign gnt_axis_o  = (req_x_i & req_y_i) ? ~last_grant_i : req_y_i;
endmodule

// File: rtl/axis_pid_scheduler.sv
// axis_pid_scheduler: round-robin sharing of one PID engine between the X and Y galvo axes
module axis_pid_scheduler #(
  parameter int DATA_W = galvano_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W = 8,
  parameter logic [DATA_W-1:0] DAC_RST_CODE = galvano_pkg::DAC_RST_CODE
) (
  input  logic              clk_ref,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              x_adc_valid,
  input  logic [DATA_W-1:0] x_adc_data,
  input  logic              y_adc_valid,
  input  logic [DATA_W-1:0] y_adc_data,
  input  logic [DATA_W-1:0] x_target,
  input  logic [DATA_W-1:0] y_target,
  output logic              pid_start,
  output logic              pid_axis,
  output logic [DATA_W-1:0] pid_meas,
  output logic [DATA_W-1:0] pid_target,
  input  logic              pid_done,
  input  logic [DATA_W-1:0] pid_result,
  output logic [DATA_W-1:0] x_dac_data,
  output logic              x_dac_load,
  output logic [DATA_W-1:0] y_dac_data,
  output logic              y_dac_load,
  output logic              busy,
  output logic [CNT_W-1:0]  x_overrun_cnt,
  output logic [CNT_W-1:0]  y_overrun_cnt,
  output logic [CNT_W-1:0]  timeout_cnt
);
  import galvano_pkg::*;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  state_t state_q;
  logic x_pend_q, y_pend_q, last_grant_q;
  logic [DATA_W-1:0] x_smp_q, y_smp_q;
  logic [TW-1:0] timer_q;
  logic gnt_valid, gnt_axis, dispatch, disp_x, disp_y;
  rr_arb2 u_arb (
    .req_x_i(x_pend_q),
    .req_y_i(y_pend_q),
    .last_grant_i(last_grant_q),
    .gnt_valid_o(gnt_valid),
    .gnt_axis_o(gnt_axis)
  );
  // The grant edge is the dispatch point: sample and target are taken and pend is cleared there
  assign dispatch = (state_q == S_IDLE) && enable && gnt_valid;
  assign disp_x = dispatch && (gnt_axis == AXIS_X);
  assign disp_y = dispatch && (gnt_axis == AXIS_Y);
  always_ff @(posedge clk_ref or posedge sys_rst)
    if (sys_rst) begin
      x_pend_q <= 1'b0;
      y_pend_q <= 1'b0;
      x_smp_q <= '0;
      y_smp_q <= '0;
      x_overrun_cnt <= '0;
      y_overrun_cnt <= '0;
    end else begin
      if (x_adc_valid) x_smp_q <= x_adc_data;
      if (y_adc_valid) y_smp_q <= y_adc_data;
      x_pend_q <= x_adc_valid | (x_pend_q & ~disp_x);
      y_pend_q <= y_adc_valid | (y_pend_q & ~disp_y);
      if (x_adc_valid && x_pend_q && !disp_x && x_overrun_cnt != '1) x_overrun_cnt <= x_overrun_cnt + CNT_W'(1);
      if (y_adc_valid && y_pend_q && !disp_y && y_overrun_cnt != '1) y_overrun_cnt <= y_overrun_cnt + CNT_W'(1);
    end
  always_ff @(posedge clk_ref or posedge sys_rst)
    if (sys_rst) begin
      state_q <= S_IDLE;
      last_grant_q <= AXIS_Y;
      timer_q <= '0;
      busy <= 1'b0;
      pid_start <= 1'b0;
      pid_axis <= 1'b0;
      pid_meas <= '0;
      pid_target <= '0;
      x_dac_data <= DAC_RST_CODE;
      y_dac_data <= DAC_RST_CODE;
      x_dac_load <= 1'b0;
      y_dac_load <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      pid_start <= 1'b0;
      x_dac_load <= 1'b0;
      y_dac_load <= 1'b0;
      case (state_q)
        S_IDLE: if (dispatch) begin
          state_q <= S_START;
          busy <= 1'b1;
          pid_start <= 1'b1;
          pid_axis <= gnt_axis;
          pid_meas <= gnt_axis ? y_smp_q : x_smp_q;
          pid_target <= gnt_axis ? y_target : x_target;
        end
        S_START: begin
          state_q <= S_WAIT;
          timer_q <= '0;
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (pid_done) begin
            state_q <= S_LOAD;
            if (pid_axis == AXIS_Y) begin
              y_dac_data <= pid_result;
              y_dac_load <= 1'b1;
            end else begin
              x_dac_data <= pid_result;
              x_dac_load <= 1'b1;
            end
          end else if (timer_q == T_LAST) begin
            state_q <= S_IDLE;
            busy <= 1'b0;
            last_grant_q <= pid_axis;
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end
        S_LOAD: begin
          state_q <= S_IDLE;
          busy <= 1'b0;
          last_grant_q <= pid_axis;
        end
        default: state_q <= S_IDLE;
      endcase
    end
endmodule
